// File: rtl/rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// rr_sched_pkg
// Shared definitions for the round-robin grant scheduler.
//   N_REQ           : number of requesters sharing the downstream resource
//   IW              : width of an encoded requester index
//   state_t         : scheduler FSM states (IDLE / GRANT)
//   onehot_from_idx : index -> one-hot grant vector
// ---------------------------------------------------------------------------
package rr_sched_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IW    = $clog2(N_REQ);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [IW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational circular priority search: finds the first set request bit
// at or above i_ptr, wrapping from N-1 back to 0.
// Ports:
//   i_req    [N-1:0]  request vector
//   i_ptr    [IW-1:0] search start position
//   o_found           at least one request is set
//   o_winner [IW-1:0] index of the winning requester (0 when none)
// ---------------------------------------------------------------------------
module rr_priority_pick
   import rr_sched_pkg::*;
#(
   parameter int unsigned N = N_REQ
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_found,
   output logic [IW-1:0] o_winner
);

   logic [N-1:0]  w_rot;
   logic [IW-1:0] w_offset;
   logic          w_any;

   // Rotate so that requester i_ptr lands at bit 0; a plain lowest-bit
   // priority encode then implements the circular search.
   always_comb begin
      logic [IW:0] sum;
      w_rot = '0;
      for (int i = 0; i < int'(N); i++) begin
         sum = {1'b0, i_ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         w_rot[i] = i_req[sum[IW-1:0]];
      end
   end

   // Lowest set bit of the rotated vector wins; scanning downward lets the
   // last assignment (smallest index) take effect.
   always_comb begin
      w_offset = '0;
      w_any    = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_offset = IW'(i);
            w_any    = 1'b1;
         end
      end
   end

   // Undo the rotation: winner = (offset + ptr) mod N.
   always_comb begin
      logic [IW:0] sum;
      sum = {1'b0, w_offset} + {1'b0, i_ptr};
      if (sum >= (IW+1)'(N)) begin
         sum = sum - (IW+1)'(N);
      end
      o_winner = w_any ? sum[IW-1:0] : '0;
      o_found  = w_any;
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
// Round-robin owner scheduler for one shared resource. Issues a registered
// one-hot grant with a forced one-cycle idle gap between tenures and a
// maximum tenure length of MAX_HOLD cycles (0 = unlimited).
// Ports:
//   i_clk                 system clock
//   i_rst_n               synchronous active-low reset
//   i_ena                 enable; low ends any tenure and blocks new grants
//   i_req       [N-1:0]   level-sensitive requests
//   i_release             owner's end-of-tenure pulse
//   o_grant     [N-1:0]   one-hot grant (zero when idle)
//   o_grant_idx [IW-1:0]  encoded owner (zero when idle)
//   o_grant_valid         a grant is active
//   o_timeout_flag        one-cycle pulse after a tenure ended purely by MAX_HOLD
// N must equal N_REQ from rr_sched_pkg, which sizes the index and helper.
// ---------------------------------------------------------------------------
module rr_grant_scheduler
   import rr_sched_pkg::*;
#(
   parameter int unsigned N        = N_REQ,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_ena,
   input  logic [N-1:0]  i_req,
   input  logic          i_release,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_grant_idx,
   output logic          o_grant_valid,
   output logic          o_timeout_flag
);

   localparam int unsigned   HW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t        r_state,   w_state_next;
   logic [IW-1:0] r_ptr,     w_ptr_next;
   logic [HW-1:0] r_hold_cnt, w_hold_next;
   logic [N-1:0]  r_grant,   w_grant_next;
   logic [IW-1:0] r_idx,     w_idx_next;
   logic          r_valid,   w_valid_next;
   logic          r_timeout, w_timeout_next;

   logic          w_found;
   logic [IW-1:0] w_winner;
   logic          w_hold_hit;
   logic          w_other_exit;

   rr_priority_pick #(
      .N (N)
   ) u_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_found  (w_found),
      .o_winner (w_winner)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_grant    <= '0;
         r_idx      <= '0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_hold_cnt <= w_hold_next;
         r_grant    <= w_grant_next;
         r_idx      <= w_idx_next;
         r_valid    <= w_valid_next;
         r_timeout  <= w_timeout_next;
      end
   end

   // A timeout exit only counts as a timeout when nothing else would have
   // ended the tenure in the same cycle.
   assign w_hold_hit   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);
   assign w_other_exit = i_release || !i_req[r_idx] || !i_ena;

   always_comb begin
      w_state_next   = r_state;
      w_ptr_next     = r_ptr;
      w_hold_next    = r_hold_cnt;
      w_grant_next   = r_grant;
      w_idx_next     = r_idx;
      w_valid_next   = r_valid;
      w_timeout_next = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_ena && w_found) begin
               w_state_next = GRANT;
               w_grant_next = onehot_from_idx(w_winner);
               w_idx_next   = w_winner;
               w_valid_next = 1'b1;
               w_hold_next  = HW'(1);
            end
         end
         GRANT: begin
            if (w_hold_hit || w_other_exit) begin
               w_state_next   = IDLE;
               w_grant_next   = '0;
               w_idx_next     = '0;
               w_valid_next   = 1'b0;
               w_ptr_next     = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
               w_timeout_next = w_hold_hit && !w_other_exit;
            end else if ((MAX_HOLD != 0) && (r_hold_cnt != HOLD_LIM)) begin
               w_hold_next = r_hold_cnt + HW'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign o_grant        = r_grant;
   assign o_grant_idx    = r_idx;
   assign o_grant_valid  = r_valid;
   assign o_timeout_flag = r_timeout;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_scheduler
// Directed self-checking bench for rr_grant_scheduler (N=8, MAX_HOLD=16).
// ---------------------------------------------------------------------------
module tb_rr_grant_scheduler;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] req;
   logic       rel;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout_flag;

   int n_vec = 0;
   int n_err = 0;

   rr_grant_scheduler #(
      .N        (8),
      .MAX_HOLD (16)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ena          (ena),
      .i_req          (req),
      .i_release      (rel),
      .o_grant        (grant),
      .o_grant_idx    (grant_idx),
      .o_grant_valid  (grant_valid),
      .o_timeout_flag (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et);
      logic [12:0] obs;
      logic [12:0] exp;
      obs = {grant, grant_idx, grant_valid, timeout_flag};
      exp = {eg, ei, ev, et};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed grant=%02h idx=%0d valid=%0b to=%0b, expected grant=%02h idx=%0d valid=%0b to=%0b",
                tag, grant, grant_idx, grant_valid, timeout_flag, eg, ei, ev, et);
      end
      $display("vec %0d %s: grant=%02h idx=%0d valid=%0b to=%0b", n_vec, tag,
               grant, grant_idx, grant_valid, timeout_flag);
   endtask

   task automatic check_owner(input string tag, input int owner);
      logic [7:0] oh;
      oh = 8'h01 << owner;
      check(tag, oh, 3'(owner), 1'b1, 1'b0);
   endtask

   task automatic check_idle(input string tag, input logic et);
      check(tag, 8'h00, 3'd0, 1'b0, et);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b0;
      req   = 8'h00;
      rel   = 1'b0;

      // ---- reset state ----
      step();
      step();
      check_idle("reset", 1'b0);
      rst_n = 1'b1;

      // ---- two requesters, release-driven, pointer wrap ----
      req = 8'h81;
      ena = 1'b1;
      step();
      check_owner("t1_first_grant", 0);
      step();
      check_owner("t1_hold_c2", 0);
      step();
      check_owner("t1_hold_c3", 0);
      rel = 1'b1;
      step();
      check_idle("t1_gap1", 1'b0);
      rel = 1'b0;
      step();
      check_owner("t1_next_owner7", 7);
      rel = 1'b1;
      step();
      check_idle("t1_gap2", 1'b0);
      rel = 1'b0;
      step();
      check_owner("t1_wrap_owner0", 0);
      rel = 1'b1;
      step();
      check_idle("t1_gap3", 1'b0);
      rel = 1'b0;
      // release while idle must be ignored: owner 7 next (ptr=1)
      rel = 1'b1;
      step();
      check_owner("t1_rel_in_idle_ignored", 7);
      rel = 1'b0;

      // ---- all requesting, fair rotation 0..7,0 ----
      req = 8'hFF;
      pulse_reset();
      check_idle("t2_reset", 1'b0);
      step();
      for (int k = 0; k < 9; k++) begin
         check_owner($sformatf("t2_owner%0d_c1", k % 8), k % 8);
         step();
         check_owner($sformatf("t2_owner%0d_c2", k % 8), k % 8);
         rel = 1'b1;
         step();
         check_idle($sformatf("t2_gap%0d", k), 1'b0);
         rel = 1'b0;
         step();
      end

      // ---- MAX_HOLD timeout with sole requester ----
      req = 8'h04;
      pulse_reset();
      step();
      check_owner("t3_grant_c1", 2);
      for (int c = 2; c <= 16; c++) begin
         step();
      end
      check_owner("t3_grant_c16", 2);
      step();
      check_idle("t3_timeout_gap", 1'b1);
      step();
      check_owner("t3_regrant", 2);

      // ---- coincident exit A: release on hold_cnt==16 ----
      for (int c = 2; c <= 16; c++) begin
         step();
      end
      check_owner("t4a_c16", 2);
      rel = 1'b1;
      step();
      check_idle("t4a_release_not_timeout", 1'b0);
      rel = 1'b0;
      step();
      check_owner("t4a_regrant", 2);

      // ---- coincident exit B: request drop on hold_cnt==16 ----
      for (int c = 2; c <= 16; c++) begin
         step();
      end
      check_owner("t4b_c16", 2);
      req = 8'h00;
      step();
      check_idle("t4b_drop_not_timeout", 1'b0);
      step();
      check_idle("t4b_no_req_idle", 1'b0);

      // ---- ena dropped mid-grant of owner 5 ----
      req = 8'h20;
      pulse_reset();
      step();
      check_owner("t5_owner5", 5);
      ena = 1'b0;
      step();
      check_idle("t5_ena_low_drop", 1'b0);
      step();
      check_idle("t5_ena_low_blocked", 1'b0);
      ena = 1'b1;
      req = 8'h60;
      step();
      check_owner("t5_next_owner6", 6);

      // ---- reset during grant of owner 3 ----
      req = 8'h08;
      pulse_reset();
      step();
      check_owner("t6_owner3", 3);
      req = 8'h0F;
      step();
      check_owner("t6_nonowner_change_ignored", 3);
      rst_n = 1'b0;
      step();
      check_idle("t6_reset_drops_grant", 1'b0);
      rst_n = 1'b1;
      step();
      check_owner("t6_after_reset_owner0", 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
